// File: rtl/dac_serializer.sv
`timescale 1ns/1ps
// Serialises signed PCM samples onto a left-justified three-wire DAC link,
// duplicating each sample on the left and right slots; pulls one sample per frame.
module dac_serializer #(
    parameter int unsigned width_p      = 12,
    parameter int unsigned slot_width_p = 16,
    parameter int unsigned sclk_div_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               sclk_o,
    output logic               lrclk_o,
    output logic               sdata_o,
    output logic               underrun_o
);

    localparam int unsigned frame_bits_lp = 2 * slot_width_p;
    localparam int unsigned bit_w_lp      = $clog2(frame_bits_lp);
    localparam int unsigned div_w_lp      = (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;

    localparam logic [bit_w_lp-1:0] bit_last_lp  = bit_w_lp'(frame_bits_lp - 1);
    localparam logic [bit_w_lp-1:0] slot_len_lp  = bit_w_lp'(slot_width_p);
    localparam logic [bit_w_lp-1:0] width_len_lp = bit_w_lp'(width_p);
    localparam logic [div_w_lp-1:0] div_last_lp  = div_w_lp'(sclk_div_p - 1);

    logic [div_w_lp-1:0] div_q, div_d;
    logic                sclk_q, sclk_d;
    logic [bit_w_lp-1:0] bit_cnt_q, bit_cnt_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic [width_p-1:0]  hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                ready_q, ready_d;
    logic [width_p-1:0]  sample_q, sample_d;
    logic                underrun_q, underrun_d;

    logic                sclk_tc;
    logic                fall;
    logic                frame_start;
    logic                accept;
    logic [bit_w_lp-1:0] bit_nxt;
    logic [bit_w_lp-1:0] pos;
    logic [width_p-1:0]  sample_cur;
    logic [width_p-1:0]  shifted;

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_q        <= '0;
            sclk_q       <= 1'b0;
            bit_cnt_q    <= bit_last_lp;
            lrclk_q      <= 1'b1;
            sdata_q      <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            sample_q     <= '0;
            underrun_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            sclk_q       <= sclk_d;
            bit_cnt_q    <= bit_cnt_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= ready_d;
            sample_q     <= sample_d;
            underrun_q   <= underrun_d;
        end
    end

    // Divider, bit counter, holding register and serial output next-state
    always_comb begin
        div_d        = div_q;
        sclk_d       = sclk_q;
        bit_cnt_d    = bit_cnt_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sample_d     = sample_q;
        underrun_d   = 1'b0;
        pos          = '0;
        shifted      = '0;

        sclk_tc     = (div_q == div_last_lp);
        fall        = sclk_tc & sclk_q;
        bit_nxt     = (bit_cnt_q == bit_last_lp) ? '0 : bit_cnt_q + bit_w_lp'(1);
        frame_start = fall & (bit_nxt == '0);
        accept      = valid_i & ~hold_valid_q;
        sample_cur  = sample_q;

        div_d = sclk_tc ? '0 : div_q + div_w_lp'(1);
        if (sclk_tc) begin
            sclk_d = ~sclk_q;
        end

        // An empty hold at frame start yields a silent frame; a same-cycle handshake waits a frame.
        if (frame_start) begin
            sample_cur   = hold_valid_q ? hold_q : '0;
            underrun_d   = ~hold_valid_q;
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_d       = data_i;
            hold_valid_d = 1'b1;
        end
        sample_d = sample_cur;

        if (fall) begin
            bit_cnt_d = bit_nxt;
            lrclk_d   = (bit_nxt >= slot_len_lp);
            pos       = lrclk_d ? bit_nxt - slot_len_lp : bit_nxt;
            shifted   = sample_cur << pos;
            sdata_d   = (pos < width_len_lp) ? shifted[width_p-1] : 1'b0;
        end

        ready_d = ~hold_valid_d;
    end

    assign ready_o    = ready_q;
    assign sclk_o     = sclk_q;
    assign lrclk_o    = lrclk_q;
    assign sdata_o    = sdata_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_dac_serializer.sv
`timescale 1ns/1ps
// Bench for dac_serializer: default instance plus a 4/4/1 instance, both checked
// every cycle against a frame-level arithmetic model.
module tb_dac_serializer;

    localparam int WA = 12, SA = 16, DA = 4;
    localparam int WB = 4,  SB = 4,  DB = 1;
    localparam int NFR = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [WA-1:0] data_a = '0;
    logic          valid_a = 1'b0;
    logic [WB-1:0] data_b = '0;
    logic          valid_b = 1'b0;
    logic ready_a, sclk_a, lr_a, sd_a, und_a;
    logic ready_b, sclk_b, lr_b, sd_b, und_b;
    bit   b_random = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    dac_serializer #(.width_p(WA), .slot_width_p(SA), .sclk_div_p(DA)) u_dut_a (
        .clk_i(clk), .reset_i(rst_n), .data_i(data_a), .valid_i(valid_a),
        .ready_o(ready_a), .sclk_o(sclk_a), .lrclk_o(lr_a), .sdata_o(sd_a),
        .underrun_o(und_a)
    );

    dac_serializer #(.width_p(WB), .slot_width_p(SB), .sclk_div_p(DB)) u_dut_b (
        .clk_i(clk), .reset_i(rst_n), .data_i(data_b), .valid_i(valid_b),
        .ready_o(ready_b), .sclk_o(sclk_b), .lrclk_o(lr_b), .sdata_o(sd_b),
        .underrun_o(und_b)
    );

    always #5 clk = ~clk;

    function automatic int pw(int i); return (i == 0) ? WA : WB; endfunction
    function automatic int ps(int i); return (i == 0) ? SA : SB; endfunction
    function automatic int pd(int i); return (i == 0) ? DA : DB; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle count since release, a one-deep hold, and the sample of every frame.
    int  n         [2];
    bit  hold_full [2];
    int  hold_val  [2];
    int  frame_smp [2][NFR];
    bit  frame_und [2][NFR];

    task automatic model_step(input int i, input bit v, input int d);
        int nn, k, f, d2, s2;
        bit acc;
        d2  = 2 * pd(i);
        s2  = 2 * ps(i);
        nn  = n[i] + 1;
        acc = v && !hold_full[i];
        if (nn % d2 == 0) begin
            k = nn / d2;
            if ((k - 1) % s2 == 0) begin
                f = (k - 1) / s2;
                if (f < NFR) begin
                    frame_smp[i][f] = hold_full[i] ? hold_val[i] : 0;
                    frame_und[i][f] = !hold_full[i];
                end
                hold_full[i] = 1'b0;
            end
        end
        if (acc) begin
            hold_full[i] = 1'b1;
            hold_val[i]  = d;
        end
        n[i] = nn;
    endtask

    task automatic model_expect(input int i, output int e_sclk, output int e_lr,
                                output int e_sd, output int e_und, output int e_rdy);
        int k, b, f, p, w, s, d;
        w = pw(i); s = ps(i); d = pd(i);
        k      = n[i] / (2 * d);
        e_sclk = (n[i] / d) % 2;
        e_rdy  = hold_full[i] ? 0 : 1;
        e_lr   = 1;
        e_sd   = 0;
        e_und  = 0;
        if (k > 0) begin
            b    = (k - 1) % (2 * s);
            f    = (k - 1) / (2 * s);
            p    = b % s;
            e_lr = (b >= s) ? 1 : 0;
            if (f < NFR) begin
                if (p < w) e_sd = (frame_smp[i][f] >> (w - 1 - p)) & 1;
                if ((n[i] % (2 * d) == 0) && (b == 0)) e_und = frame_und[i][f] ? 1 : 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                n[i] = 0;
                hold_full[i] = 1'b0;
                hold_val[i] = 0;
            end
        end else begin
            model_step(0, valid_a, int'(data_a));
            model_step(1, valid_b, int'(data_b));
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        int es, el, ed, eu, er;
        for (int i = 0; i < 2; i++) begin
            model_expect(i, es, el, ed, eu, er);
            check((i == 0) ? "a_sclk"  : "b_sclk",  32'((i == 0) ? sclk_a  : sclk_b),  32'(es));
            check((i == 0) ? "a_lrclk" : "b_lrclk", 32'((i == 0) ? lr_a    : lr_b),    32'(el));
            check((i == 0) ? "a_sdata" : "b_sdata", 32'((i == 0) ? sd_a    : sd_b),    32'(ed));
            check((i == 0) ? "a_under" : "b_under", 32'((i == 0) ? und_a   : und_b),   32'(eu));
            check((i == 0) ? "a_ready" : "b_ready", 32'((i == 0) ? ready_a : ready_b), 32'(er));
        end
    end

    // Random sample changes on the small instance while its ready is high
    always @(negedge clk) begin
        if (rst_n && b_random && ready_b) data_b = WB'($urandom);
    end

    task automatic wait_n(input int i, input int target);
        int guard = 0;
        while (n[i] < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n[i] < target) begin
            n_fail++;
            $display("FAIL wait_n: cycle %0d reached, required %0d", n[i], target);
        end
    endtask

    task automatic send_a(input logic [WA-1:0] d, input bit keep);
        int guard = 0;
        data_a  = d;
        valid_a = 1'b1;
        while (ready_a !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL send_a: ready stayed %b, required 1", ready_a);
        end
        @(negedge clk);
        if (!keep) valid_a = 1'b0;
    endtask

    task automatic capture_a(input int fs, input int nbits, output logic [31:0] w);
        w = '0;
        for (int p = 0; p < nbits; p++) begin
            wait_n(0, fs + 2 * DA * p);
            w = {w[30:0], sd_a};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [WA-1:0] rnd;

        repeat (3) @(negedge clk);
        check("rst_ready_a", 32'(ready_a), 32'd1);
        check("rst_lrclk_a", 32'(lr_a),    32'd1);
        check("rst_sclk_b",  32'(sclk_b),  32'd0);
        rst_n = 1'b1;

        fork
            begin
                valid_b = 1'b1;
                data_b  = 4'hB;
                wait_n(1, 1);
                check("b_sclk_first_high", 32'(sclk_b), 32'd1);
                w = '0;
                for (int j = 0; j < 8; j++) begin
                    wait_n(1, 2 + 2 * j);
                    w = {w[30:0], sd_b};
                end
                check("b_frame0_bits", w, 32'hBB);
                b_random = 1'b1;
            end
            begin
                logic [31:0] wa;
                send_a(12'hA5C, 1'b0);
                wait_n(0, 4);
                check("a_sclk_rise_c4", 32'(sclk_a), 32'd1);
                wait_n(0, 7);
                check("a_lr_before_fs", 32'(lr_a), 32'd1);
                capture_a(8, 32, wa);
                check("a_frame0_bits", wa, 32'hA5C0A5C0);
                wait_n(0, 264);
                check("a_underrun_pulse", 32'(und_a), 32'd1);
                wait_n(0, 265);
                check("a_underrun_end", 32'(und_a), 32'd0);
                wait_n(0, 400);
                send_a(12'h123, 1'b0);
                wait_n(0, 520);
                check("a_recover_no_pulse", 32'(und_a), 32'd0);
                capture_a(520, 4, wa);
                check("a_recover_top", wa, 32'h1);
            end
        join

        fork
            begin
                send_a(12'h7FF, 1'b1);
                send_a(12'h800, 1'b1);
                send_a(12'h001, 1'b0);
            end
            begin
                capture_a(776, 12, w);
                check("bp_word0", w, 32'h7FF);
                capture_a(1032, 12, w);
                check("bp_word1", w, 32'h800);
                capture_a(1288, 12, w);
                check("bp_word2", w, 32'h001);
            end
            begin
                wait_n(0, 900);
                check("bp_ready_low", 32'(ready_a), 32'd0);
            end
        join

        wait_n(0, 1799);
        send_a(12'h5A5, 1'b0);
        check("simul_underrun", 32'(und_a), 32'd1);
        check("simul_ready_low", 32'(ready_a), 32'd0);
        wait_n(0, 2056);
        check("simul_next_no_pulse", 32'(und_a), 32'd0);
        capture_a(2056, 12, w);
        check("simul_word", w, 32'h5A5);

        for (int s = 0; s < 8; s++) begin
            repeat ($urandom_range(0, 400)) @(negedge clk);
            send_a(WA'($urandom), 1'b0);
        end
        repeat (300) @(negedge clk);

        repeat ($urandom_range(1, 100)) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        valid_a = 1'b0;
        #1;
        check("mid_rst_ready_a", 32'(ready_a), 32'd1);
        check("mid_rst_sclk_a",  32'(sclk_a),  32'd0);
        check("mid_rst_lrclk_a", 32'(lr_a),    32'd1);
        check("mid_rst_sdata_a", 32'(sd_a),    32'd0);
        check("mid_rst_under_a", 32'(und_a),   32'd0);
        check("mid_rst_lrclk_b", 32'(lr_b),    32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rnd = WA'($urandom);
        send_a(rnd, 1'b0);
        wait_n(0, 7);
        check("post_rst_lr_hold", 32'(lr_a), 32'd1);
        wait_n(0, 8);
        check("post_rst_no_pulse", 32'(und_a), 32'd0);
        check("post_rst_lr_fs", 32'(lr_a), 32'd0);
        capture_a(8, 12, w);
        check("post_rst_word", w, 32'(rnd));
        wait_n(0, 8 + 256 * 2 + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
# dac_serializer

Consumer-side sample sink for the audio path. Pulls signed PCM samples from a tone generator over a ready/valid handshake and transmits each sample serially on a left-justified, I2S-style three-wire link (bit clock, word select, serial data) toward an external DAC. The sample is duplicated on the left and right slots. The serializer sets the sample rate: it raises `ready_o` once per frame, which paces the upstream generator's address counter.

## Interface
- `width_p`, 12, sample width in bits (signed, two's complement)
- `slot_width_p`, 16, bit clocks per channel slot; must be ≥ `width_p`
- `sclk_div_p`, 4, `clk_i` cycles per half period of `sclk_o`; must be ≥ 1

- `clk_i`  in  1  system clock; all state changes on its rising edge
- `reset_i`  in  1  asynchronous, active-low reset
- `data_i`  in  `width_p`  signed sample from the generator
- `valid_i`  in  1  `data_i` is valid
- `ready_o`  out  1  holding register empty; a sample is taken when `valid_i & ready_o`
- `sclk_o`  out  1  serial bit clock
- `lrclk_o`  out  1  word select; 0 = left slot, 1 = right slot
- `sdata_o`  out  1  serial data, MSB first
- `underrun_o`  out  1  one-cycle pulse when a frame starts with no sample available

## Operation
- **Holding register** (`hold_r`, `hold_valid_r`)
  - `ready_o` = `~hold_valid_r`.
  - A handshake loads `hold_r` and sets `hold_valid_r`.
- **Divider**
  - `div_r` counts 0..`sclk_div_p`-1 and wraps.
  - At terminal count, `sclk_o` toggles.
  - A toggle from 1 to 0 is a *falling event*.
- **Bit counter**
  - `bit_r` counts 0..2·`slot_width_p`-1.
  - It advances by 1 on each falling event and wraps to 0.
  - A falling event that takes `bit_r` to 0 is a *frame start*.
- **Frame start**
  - If `hold_valid_r`=1: `sample_r` ← `hold_r` and `hold_valid_r` is cleared in the same cycle.
  - Otherwise: `sample_r` ← 0 and `underrun_o` pulses high for that cycle.
  - A handshake in the same cycle as an empty-hold frame start fills `hold_r` for the next frame. It does not fill the current frame.
- **Outputs on each falling event**, with p = new `bit_r` mod `slot_width_p`:
  - `lrclk_o` ← (new `bit_r` ≥ `slot_width_p`).
  - `sdata_o` ← `sample_r[width_p-1-p]` when p < `width_p`, else 0.
  - `sample_r` here is the value loaded at that same frame start.
- **Format**
  - Left-justified: the MSB appears on the same falling event as the `lrclk_o` transition.
  - The right slot repeats the left-slot bits exactly.
- **Arithmetic**: none on sample data. Bits are forwarded unmodified, including the sign.

## Timing
- **Reset values (asynchronous)**
  - `div_r`=0, `sclk_o`=0, `bit_r`=2·`slot_width_p`-1, `lrclk_o`=1, `sdata_o`=0.
  - `hold_valid_r`=0 (so `ready_o`=1), `underrun_o`=0, `sample_r`=0.
- **After reset release**
  - First rising `sclk_o` toggle: `sclk_o` goes high after the rising edge of cycle `sclk_div_p`.
  - First falling event is the first frame start, `2·sclk_div_p` cycles after release.
- **Periods**
  - `sclk_o` period = 2·`sclk_div_p` cycles.
  - Frame = 4·`slot_width_p`·`sclk_div_p` cycles (256 with defaults).
- **Handshake**
  - At most one sample is accepted per frame in steady state.
  - `ready_o` rises the cycle after a frame-start load.
  - `valid_i` may stay high across frames. `data_i` must be held while `valid_i & ~ready_o`.
- **Latency**: a sample accepted before a frame start drives its MSB on `sdata_o` at that frame start.
- **Reset mid-frame**: outputs return to reset values immediately and any held sample is discarded. The frame restarts cleanly after release with no partial-frame glitch beyond the reset values.
- **Underrun recovery**: the frame is all zeros. The next frame uses a sample accepted during the underrun frame.

## Test plan
- **Reset values**: assert `reset_i`=0 mid-run → outputs at reset values that same cycle, with no clock edge needed; release → first frame start at cycle 8 (defaults).
- **Single sample**: after reset, `data_i`=12'hA5C with `valid_i` for 1 cycle → on consecutive falling events, `sdata_o` = 1010 0101 1100 0000 with `lrclk_o`=0, then the same 16 bits with `lrclk_o`=1; `sclk_o` period 8, frame 256 cycles.
- **Backpressure**: `valid_i` held high with 3 distinct samples (12'h7FF, 12'h800, 12'h001) → `ready_o` low between frame starts; each sample occupies exactly one frame, in order; none dropped or duplicated.
- **Underrun**: no `valid_i` for a frame → `underrun_o` one-cycle pulse at the frame start and 32 zero bits; a sample supplied mid-frame appears in the next frame and produces no pulse.
- **Simultaneous**: `valid_i` rises in the exact frame-start cycle with the hold empty → underrun pulse, and the sample is transmitted in the following frame.
- **Parameter sweep**: `width_p`=4, `slot_width_p`=4, `sclk_div_p`=1 → no padding bits, `sclk_o` toggles every cycle, 4'hB sent as 1011 1011 per frame.
